// File: rtl/sparse_buffer_pkg.sv
// Shared types and helpers for the sparse operand buffer: FSM states, count width, popcount.
package sparse_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } bufferState_t;

    localparam int MAX_WINDOW = 1024;

    function automatic int cntWidth(input int transferSize);
        return $clog2(transferSize) + 1;
    endfunction

    function automatic int unsigned popCount(input logic [MAX_WINDOW-1:0] vec);
        int unsigned total;
        total = 32'd0;
        for (int i = 0; i < MAX_WINDOW; i++) begin
            total = total + (vec[i] ? 32'd1 : 32'd0);
        end
        return total;
    endfunction

endpackage

// File: rtl/sparse_cluster_compactor.sv
// Combinational mask-select of one transfer block appended behind the residual clusters.
// Kept/present counts are exported only when SPARSE_BUFFER_STATS_EN is defined.
module sparse_cluster_compactor
    import sparse_buffer_pkg::*;
#(
    parameter int TRANSFER_SIZE           = 4,
    parameter int CLUSTER_BITWIDTH        = 8,
    parameter int COMPRESSION_WINDOW_SIZE = 32,
    localparam int CNT_W = cntWidth(TRANSFER_SIZE),
    localparam int BLK_W = TRANSFER_SIZE * CLUSTER_BITWIDTH,
    localparam int IDX_W = $clog2(COMPRESSION_WINDOW_SIZE + 1)
) (
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] bitmask,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] mutualBitmask,
    input  logic [IDX_W-1:0]                   blockIndex,
    input  logic [BLK_W-1:0]                   blockData,
    input  logic [BLK_W-1:0]                   residualData,
    input  logic [CNT_W-1:0]                   residualCount,
    output logic [2*BLK_W-1:0]                 sumData,
    output logic [CNT_W:0]                     sumCount
`ifdef SPARSE_BUFFER_STATS_EN
    ,
    output logic [CNT_W-1:0]                   presentCount,
    output logic [CNT_W-1:0]                   keptCount
`endif
);

    localparam int unsigned TS = TRANSFER_SIZE;
    localparam int LANE_W = (TRANSFER_SIZE > 1) ? $clog2(TRANSFER_SIZE) : 1;
    localparam int SLOT_W = $clog2(2 * TRANSFER_SIZE);

    logic [TRANSFER_SIZE-1:0][CLUSTER_BITWIDTH-1:0] blkLanes;
    assign blkLanes = blockData;

    // Walk the window once: the set bits ranked inside this block pick lanes, kept ones pack in order
    always_comb begin
        logic [2*TRANSFER_SIZE-1:0][CLUSTER_BITWIDTH-1:0] lanes;
        int unsigned rank;
        int unsigned base;
        int unsigned kept;
        int unsigned present;
        logic inBlock;
        logic keep;
        logic [LANE_W-1:0] lane;
        logic [SLOT_W-1:0] slot;
        lanes   = (2*BLK_W)'(residualData);
        rank    = 32'd0;
        base    = 32'(blockIndex) * TS;
        kept    = 32'd0;
        present = 32'd0;
        inBlock = 1'b0;
        keep    = 1'b0;
        lane    = '0;
        slot    = '0;
        for (int p = 0; p < COMPRESSION_WINDOW_SIZE; p++) begin
            inBlock = bitmask[p] && (rank >= base) && (rank < base + TS);
            keep    = inBlock && mutualBitmask[p];
            lane    = LANE_W'(rank - base);
            slot    = SLOT_W'(int'(residualCount) + int'(kept));
            lanes[slot] = keep ? blkLanes[lane] : lanes[slot];
            kept    = kept + (keep ? 32'd1 : 32'd0);
            present = present + (inBlock ? 32'd1 : 32'd0);
            rank    = rank + (bitmask[p] ? 32'd1 : 32'd0);
        end
        sumData  = lanes;
        sumCount = (CNT_W+1)'(int'(residualCount) + int'(kept));
`ifdef SPARSE_BUFFER_STATS_EN
        presentCount = CNT_W'(present);
        keptCount    = CNT_W'(kept);
`endif
    end

endmodule

// File: rtl/sparse_operand_buffer.sv
// Sparse operand buffer: expands masked compressed blocks into dense MAC groups.
// Optional SPARSE_BUFFER_STATS_EN adds saturating kept/dropped cluster counters.
module sparse_operand_buffer
    import sparse_buffer_pkg::*;
#(
    parameter int TRANSFER_SIZE           = 4,
    parameter int CLUSTER_BITWIDTH        = 8,
    parameter int COMPRESSION_WINDOW_SIZE = 32,
    localparam int CNT_W = cntWidth(TRANSFER_SIZE),
    localparam int BLK_W = TRANSFER_SIZE * CLUSTER_BITWIDTH
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               i_window_valid,
    output logic                               o_window_ready,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] i_bitmask,
    input  logic [COMPRESSION_WINDOW_SIZE-1:0] i_mutual_bitmask,
    input  logic                               i_block_valid,
    output logic                               o_block_ready,
    input  logic [BLK_W-1:0]                   i_block_data,
    output logic                               o_mac_valid,
    input  logic                               i_mac_ready,
    output logic [BLK_W-1:0]                   o_mac_data,
    output logic [CNT_W-1:0]                   o_mac_count,
    output logic                               o_mac_last
`ifdef SPARSE_BUFFER_STATS_EN
    ,
    output logic [15:0]                        o_kept_count,
    output logic [15:0]                        o_dropped_count
`endif
);

    localparam int IDX_W = $clog2(COMPRESSION_WINDOW_SIZE + 1);
    localparam int unsigned TS = TRANSFER_SIZE;

    bufferState_t                     state;
    logic [COMPRESSION_WINDOW_SIZE-1:0] bitmaskReg;
    logic [COMPRESSION_WINDOW_SIZE-1:0] mutualReg;
    logic [IDX_W-1:0]                 numBlocks;
    logic [IDX_W-1:0]                 blockIndex;
    logic [BLK_W-1:0]                 residualData;
    logic [CNT_W-1:0]                 residualCount;
    logic [2*BLK_W-1:0]               sumData;
    logic [CNT_W:0]                   sumCount;
    logic [IDX_W-1:0]                 nbNext;
    logic                             outFree;
    logic                             blockFire;
    logic                             lastBlock;
    logic                             sumFull;
    logic [CNT_W-1:0]                 remCount;

`ifdef SPARSE_BUFFER_STATS_EN
    logic [CNT_W-1:0] blockPresent;
    logic [CNT_W-1:0] blockKept;
`endif

    sparse_cluster_compactor #(
        .TRANSFER_SIZE          (TRANSFER_SIZE),
        .CLUSTER_BITWIDTH       (CLUSTER_BITWIDTH),
        .COMPRESSION_WINDOW_SIZE(COMPRESSION_WINDOW_SIZE)
    ) compactor (
        .bitmask      (bitmaskReg),
        .mutualBitmask(mutualReg),
        .blockIndex   (blockIndex),
        .blockData    (i_block_data),
        .residualData (residualData),
        .residualCount(residualCount),
        .sumData      (sumData),
        .sumCount     (sumCount)
`ifdef SPARSE_BUFFER_STATS_EN
        ,
        .presentCount (blockPresent),
        .keptCount    (blockKept)
`endif
    );

    assign nbNext    = IDX_W'((popCount(MAX_WINDOW'(i_bitmask)) + TS - 32'd1) / TS);
    assign outFree   = !o_mac_valid || i_mac_ready;
    assign o_window_ready = (state == IDLE);
    assign o_block_ready  = (state == STREAM) && outFree;
    assign blockFire = i_block_valid && o_block_ready;
    assign lastBlock = (blockIndex == numBlocks - IDX_W'(1));
    assign sumFull   = (sumCount >= (CNT_W+1)'(TRANSFER_SIZE));
    assign remCount  = CNT_W'(sumCount - (CNT_W+1)'(TRANSFER_SIZE));

    // Window FSM, residual buffer and MAC output register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            bitmaskReg    <= '0;
            mutualReg     <= '0;
            numBlocks     <= '0;
            blockIndex    <= '0;
            residualData  <= '0;
            residualCount <= '0;
            o_mac_valid   <= 1'b0;
            o_mac_data    <= '0;
            o_mac_count   <= '0;
            o_mac_last    <= 1'b0;
        end else begin
            if (o_mac_valid && i_mac_ready) begin
                o_mac_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (i_window_valid) begin
                        bitmaskReg    <= i_bitmask;
                        mutualReg     <= i_mutual_bitmask;
                        numBlocks     <= nbNext;
                        blockIndex    <= '0;
                        residualData  <= '0;
                        residualCount <= '0;
                        state         <= (nbNext != IDX_W'(0)) ? STREAM : DRAIN;
                    end
                end
                STREAM: begin
                    if (blockFire) begin
                        blockIndex <= blockIndex + IDX_W'(1);
                        if (sumFull) begin
                            o_mac_valid   <= 1'b1;
                            o_mac_data    <= sumData[BLK_W-1:0];
                            o_mac_count   <= CNT_W'(TRANSFER_SIZE);
                            o_mac_last    <= lastBlock && (remCount == CNT_W'(0));
                            residualData  <= sumData[2*BLK_W-1:BLK_W];
                            residualCount <= remCount;
                            if (lastBlock) begin
                                state <= (remCount == CNT_W'(0)) ? IDLE : DRAIN;
                            end
                        end else if (lastBlock && (sumCount != (CNT_W+1)'(0))) begin
                            o_mac_valid   <= 1'b1;
                            o_mac_data    <= sumData[BLK_W-1:0];
                            o_mac_count   <= CNT_W'(sumCount);
                            o_mac_last    <= 1'b1;
                            residualData  <= '0;
                            residualCount <= '0;
                            state         <= IDLE;
                        end else begin
                            // Nothing to emit yet; an empty last block leaves DRAIN to carry the last flag
                            residualData  <= sumData[BLK_W-1:0];
                            residualCount <= CNT_W'(sumCount);
                            if (lastBlock) begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (outFree) begin
                        o_mac_valid   <= 1'b1;
                        o_mac_data    <= residualData;
                        o_mac_count   <= residualCount;
                        o_mac_last    <= 1'b1;
                        residualData  <= '0;
                        residualCount <= '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPARSE_BUFFER_STATS_EN
    logic [16:0] keptSum;
    logic [16:0] droppedSum;
    assign keptSum    = {1'b0, o_kept_count} + 17'(blockKept);
    assign droppedSum = {1'b0, o_dropped_count} + 17'(blockPresent - blockKept);

    // Saturating counters of present clusters kept or dropped by the mutual mask
    always_ff @(posedge clock) begin
        if (!resetn) begin
            o_kept_count    <= 16'd0;
            o_dropped_count <= 16'd0;
        end else if (blockFire) begin
            o_kept_count    <= keptSum[16] ? 16'hFFFF : keptSum[15:0];
            o_dropped_count <= droppedSum[16] ? 16'hFFFF : droppedSum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_sparse_operand_buffer.sv
// Directed self-checking bench for sparse_operand_buffer; stats checks when SPARSE_BUFFER_STATS_EN is defined.
module tb_sparse_operand_buffer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        i_window_valid = 1'b0;
    logic        o_window_ready;
    logic [31:0] i_bitmask = 32'd0;
    logic [31:0] i_mutual_bitmask = 32'd0;
    logic        i_block_valid = 1'b0;
    logic        o_block_ready;
    logic [31:0] i_block_data = 32'd0;
    logic        o_mac_valid;
    logic        i_mac_ready = 1'b1;
    logic [31:0] o_mac_data;
    logic [2:0]  o_mac_count;
    logic        o_mac_last;
`ifdef SPARSE_BUFFER_STATS_EN
    logic [15:0] o_kept_count;
    logic [15:0] o_dropped_count;
`endif

    int checkCount = 0;
    int failCount = 0;
    int blockAccepts = 0;
    logic [31:0] grpData[$];
    int          grpCount[$];
    bit          grpLast[$];

    always #5 clock = ~clock;

    sparse_operand_buffer dut (
        .clock           (clock),
        .resetn          (resetn),
        .i_window_valid  (i_window_valid),
        .o_window_ready  (o_window_ready),
        .i_bitmask       (i_bitmask),
        .i_mutual_bitmask(i_mutual_bitmask),
        .i_block_valid   (i_block_valid),
        .o_block_ready   (o_block_ready),
        .i_block_data    (i_block_data),
        .o_mac_valid     (o_mac_valid),
        .i_mac_ready     (i_mac_ready),
        .o_mac_data      (o_mac_data),
        .o_mac_count     (o_mac_count),
        .o_mac_last      (o_mac_last)
`ifdef SPARSE_BUFFER_STATS_EN
        ,
        .o_kept_count    (o_kept_count),
        .o_dropped_count (o_dropped_count)
`endif
    );

    // Record handshakes that will complete on the coming rising edge
    always @(negedge clock) begin
        #2;
        if (resetn && o_mac_valid && i_mac_ready) begin
            grpData.push_back(o_mac_data);
            grpCount.push_back(int'(o_mac_count));
            grpLast.push_back(o_mac_last);
        end
        if (resetn && i_block_valid && o_block_ready) begin
            blockAccepts++;
        end
    end

    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] blockWord(input int k);
        return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    endfunction

    task automatic sendWindow(input logic [31:0] bm, input logic [31:0] mm);
        int waited = 0;
        @(negedge clock);
        i_window_valid = 1'b1;
        i_bitmask = bm;
        i_mutual_bitmask = mm;
        #1;
        while (!o_window_ready && waited < 100) begin
            @(negedge clock);
            #1;
            waited++;
        end
        checkValue("window_accept", 64'(waited < 100), 64'd1);
        @(negedge clock);
        i_window_valid = 1'b0;
    endtask

    task automatic sendBlock(input logic [31:0] data);
        int waited = 0;
        @(negedge clock);
        i_block_valid = 1'b1;
        i_block_data = data;
        #1;
        while (!o_block_ready && waited < 100) begin
            @(negedge clock);
            #1;
            waited++;
        end
        checkValue("block_accept", 64'(waited < 100), 64'd1);
        @(negedge clock);
        i_block_valid = 1'b0;
    endtask

    task automatic runWindow(input logic [31:0] bm, input logic [31:0] mm, input int nBlocks);
        sendWindow(bm, mm);
        for (int k = 0; k < nBlocks; k++) begin
            sendBlock(blockWord(k));
        end
    endtask

    task automatic waitGroups(input int n);
        int waited = 0;
        while (grpData.size() < n && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        checkValue($sformatf("groups_%0d_seen", n), 64'(grpData.size() >= n), 64'd1);
    endtask

    task automatic clearGroups();
        grpData.delete();
        grpCount.delete();
        grpLast.delete();
    endtask

    task automatic checkBasicGroups(input string tag);
        logic [31:0] expData[4];
        expData[0] = 32'h04030201;
        expData[1] = 32'h100F0E0D;
        expData[2] = 32'h14131211;
        expData[3] = 32'h201F1E1D;
        waitGroups(4);
        repeat (5) @(negedge clock);
        checkValue({tag, "_ngroups"}, 64'(grpData.size()), 64'd4);
        for (int i = 0; i < 4 && i < grpData.size(); i++) begin
            checkValue($sformatf("%s_g%0d_data", tag, i), 64'(grpData[i]), 64'(expData[i]));
            checkValue($sformatf("%s_g%0d_count", tag, i), 64'(grpCount[i]), 64'd4);
            checkValue($sformatf("%s_g%0d_last", tag, i), 64'(grpLast[i]), 64'(i == 3));
        end
        checkValue({tag, "_idle"}, 64'(o_window_ready), 64'd1);
        clearGroups();
    endtask

    initial begin
        int acceptsBefore;
        repeat (3) @(negedge clock);
        #1;
        checkValue("rst_mac_valid", 64'(o_mac_valid), 64'd0);
        checkValue("rst_mac_data", 64'(o_mac_data), 64'd0);
        checkValue("rst_mac_count", 64'(o_mac_count), 64'd0);
        checkValue("rst_mac_last", 64'(o_mac_last), 64'd0);
        checkValue("rst_block_ready", 64'(o_block_ready), 64'd0);
        checkValue("rst_window_ready", 64'(o_window_ready), 64'd1);
        resetn = 1'b1;

        runWindow(32'hFFFFFFFF, 32'hF00FF00F, 8);
        checkBasicGroups("basic");

        sendWindow(32'hFFFFFFFF, 32'h00000007);
        for (int k = 0; k < 7; k++) sendBlock(blockWord(k));
        repeat (3) @(negedge clock);
        checkValue("partial_none_early", 64'(grpData.size()), 64'd0);
        sendBlock(blockWord(7));
        waitGroups(1);
        repeat (3) @(negedge clock);
        checkValue("partial_ngroups", 64'(grpData.size()), 64'd1);
        checkValue("partial_data", 64'(grpData[0]), 64'h00030201);
        checkValue("partial_count", 64'(grpCount[0]), 64'd3);
        checkValue("partial_last", 64'(grpLast[0]), 64'd1);
        clearGroups();

        acceptsBefore = blockAccepts;
        sendWindow(32'h00000000, 32'hFFFFFFFF);
        @(negedge clock);
        i_block_valid = 1'b1;
        i_block_data = 32'hDEADBEEF;
        waitGroups(1);
        repeat (3) @(negedge clock);
        i_block_valid = 1'b0;
        checkValue("empty_ngroups", 64'(grpData.size()), 64'd1);
        checkValue("empty_count", 64'(grpCount[0]), 64'd0);
        checkValue("empty_data", 64'(grpData[0]), 64'd0);
        checkValue("empty_last", 64'(grpLast[0]), 64'd1);
        checkValue("empty_no_block", 64'(blockAccepts - acceptsBefore), 64'd0);
        checkValue("empty_idle", 64'(o_window_ready), 64'd1);
        clearGroups();

        fork
            runWindow(32'hFFFFFFFF, 32'hF00FF00F, 8);
            begin
                int waited = 0;
                @(negedge clock);
                while (!o_mac_valid && waited < 200) begin
                    @(negedge clock);
                    waited++;
                end
                checkValue("stall_first_seen", 64'(o_mac_valid), 64'd1);
                i_mac_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    checkValue($sformatf("stall_c%0d_valid", c), 64'(o_mac_valid), 64'd1);
                    checkValue($sformatf("stall_c%0d_data", c), 64'(o_mac_data), 64'h04030201);
                    checkValue($sformatf("stall_c%0d_bready", c), 64'(o_block_ready), 64'd0);
                    @(negedge clock);
                end
                i_mac_ready = 1'b1;
            end
        join
        checkBasicGroups("stall");

        i_mac_ready = 1'b0;
        sendWindow(32'hFFFFFFFF, 32'hFFFFFFFF);
        sendBlock(blockWord(0));
        #1;
        checkValue("held_valid", 64'(o_mac_valid), 64'd1);
        resetn = 1'b0;
        @(negedge clock);
        #1;
        checkValue("held_rst_valid", 64'(o_mac_valid), 64'd0);
        checkValue("held_rst_data", 64'(o_mac_data), 64'd0);
        checkValue("held_rst_count", 64'(o_mac_count), 64'd0);
        checkValue("held_rst_wready", 64'(o_window_ready), 64'd1);
        resetn = 1'b1;
        i_mac_ready = 1'b1;
        checkValue("held_no_groups", 64'(grpData.size()), 64'd0);

        runWindow(32'hFFFFFFFF, 32'hF00FF00F, 3);
        resetn = 1'b0;
        @(negedge clock);
        #1;
        checkValue("midrst_mac_valid", 64'(o_mac_valid), 64'd0);
        checkValue("midrst_window_ready", 64'(o_window_ready), 64'd1);
        checkValue("midrst_block_ready", 64'(o_block_ready), 64'd0);
        resetn = 1'b1;
        clearGroups();
        runWindow(32'hFFFFFFFF, 32'hF00FF00F, 8);
        checkBasicGroups("rerun");
`ifdef SPARSE_BUFFER_STATS_EN
        checkValue("stats_kept", 64'(o_kept_count), 64'd16);
        checkValue("stats_dropped", 64'(o_dropped_count), 64'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sparse_operand_buffer.md
SPARSE_OPERAND_BUFFER -- requirements
Module: sparse_operand_buffer

Interface
REQ-001 SHALL have parameter TRANSFER_SIZE, default 4: clusters per transfer block and per MAC group.
REQ-002 SHALL have parameter CLUSTER_BITWIDTH, default 8: bits per cluster.
REQ-003 SHALL have parameter COMPRESSION_WINDOW_SIZE, default 32: bitmask positions per window.
REQ-004 Ports SHALL be as follows; CNT_W = clog2(TRANSFER_SIZE)+1, BLK_W = TRANSFER_SIZE*CLUSTER_BITWIDTH:
  clock             in   1              sole clock, rising edge
  resetn            in   1              synchronous, active-low reset
  i_window_valid    in   1              window descriptor valid
  o_window_ready    out  1              descriptor accepted
  i_bitmask         in   WINDOW_SIZE    positions present in compressed stream
  i_mutual_bitmask  in   WINDOW_SIZE    positions to keep
  i_block_valid     in   1              transfer block valid
  o_block_ready     out  1              block accepted
  i_block_data      in   BLK_W          compressed clusters, lane 0 = bits [CLUSTER_BITWIDTH-1:0]
  o_mac_valid       out  1              MAC group valid
  i_mac_ready       in   1              MAC group consumed
  o_mac_data        out  BLK_W          kept clusters, lane 0 = earliest
  o_mac_count       out  CNT_W          valid lanes, 0..TRANSFER_SIZE
  o_mac_last        out  1              final group of the window

Function
REQ-005 FSM states: IDLE, STREAM, DRAIN.
REQ-006 IDLE: o_window_ready=1; on i_window_valid, latch both masks, set NB = ceil(popcount(i_bitmask)/TRANSFER_SIZE), clear block index; go STREAM if NB>0, else DRAIN.
REQ-007 Cluster j of block k maps to the (k*TRANSFER_SIZE+j)-th set bit of the latched bitmask; clusters beyond popcount are ignored; a cluster is kept iff the mutual bit at its mapped position is 1.
REQ-008 STREAM: o_block_ready = !o_mac_valid || i_mac_ready; each accepted block appends its kept clusters, in order, behind a residual buffer of 0..TRANSFER_SIZE-1 clusters.
REQ-009 If residual+kept >= TRANSFER_SIZE: the first TRANSFER_SIZE clusters are registered as a full group (count=TRANSFER_SIZE) and the remainder becomes the residual.
REQ-010 Latency: group visible on o_mac_* the cycle after the block handshake; at most one group per accepted block.
REQ-011 On the last block (index NB-1): a full group is emitted with last=1 iff the remainder is 0; a nonzero sum below TRANSFER_SIZE is emitted immediately as a partial group with last=1; otherwise go DRAIN; else go IDLE.
REQ-012 DRAIN: when the output register is free, emit the residual (count 0..TRANSFER_SIZE-1) with last=1, clear residual, go IDLE; a count-0 group occurs only when no other group can carry last.
REQ-013 Output register holds o_mac_* stable while o_mac_valid && !i_mac_ready; unused lanes SHALL be zero.
REQ-014 Window descriptors are not accepted outside IDLE; blocks are not accepted outside STREAM.

Reset
REQ-015 When resetn=0 at a clock edge: state=IDLE, residual cleared, block index 0, o_mac_valid=0, o_mac_data=0, o_mac_count=0, o_mac_last=0, o_block_ready=0; o_window_ready=1 from the next cycle.
REQ-016 Reset mid-window SHALL discard all buffered clusters with no partial output.

Configuration
REQ-017 With SPARSE_BUFFER_STATS_EN defined: outputs o_kept_count[15:0] and o_dropped_count[15:0], saturating, increment per present cluster kept/dropped, cleared by reset; without it, the ports and logic are absent.

Structure
REQ-018 Package sparse_buffer_pkg SHALL hold CNT_W derivation, the FSM state enum and the popcount function.
REQ-019 Sub-module sparse_cluster_compactor SHALL be the combinational mask-select and append to residual; FSM and registers live in the top module.

Verification
REQ-020 Masks 0xFFFFFFFF/0xF00FF00F, blocks 0x04030201..0x201F1E1D, i_mac_ready=1 -> groups 0x04030201, 0x100F0E0D, 0x14131211, 0x201F1E1D, count 4, last only on 4th.
REQ-021 Masks 0xFFFFFFFF/0x00000007, same 8 blocks -> one group 0x00030201, count 3, last=1, after the 8th block.
REQ-022 Bitmask 0x00000000 -> no block accepted; one group count 0, last=1; returns to IDLE.
REQ-023 REQ-020 stimulus with i_mac_ready=0 for 5 cycles after the first group -> o_block_ready=0, output stable, same 4 groups in order.
REQ-024 resetn=0 after 3 blocks of REQ-020 -> next cycle o_mac_valid=0, o_window_ready=1; rerunning REQ-020 gives the REQ-020 result.
REQ-025 SPARSE_BUFFER_STATS_EN, REQ-020 stimulus -> o_kept_count=16, o_dropped_count=16.
